imem_ctrl: RTL
==============

Name: imem_ctrl

Overview:
Parametrised instruction memory with a handshaked fetch port for the core and a handshaked programming port for the UART loader. Read is synchronous (1-cycle latency) so the array can map to SRAM/registers-as-RAM. An optional post-reset clear sweep fills the array with NOPs. Range and alignment errors are flagged rather than silently aliased. Sits between the core fetch stage and the UART programming path.

Parameters:
XLEN, 32, instruction word width in bits
DEPTH, 256, number of words; must be a power of two, at least 2; AW = clog2(DEPTH) is derived locally
NOP_WORD, 32'h00000013, word returned on errors and written by the clear sweep
CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = enter READY directly and leave contents undefined

Ports:
CLK  in  1  clock, all state updates on the rising edge
RST_N  in  1  asynchronous, active-low reset
F_REQ  in  1  fetch request
F_ADDR  in  32  fetch byte address
F_GNT  out  1  fetch accepted this cycle (combinational)
F_RVALID  out  1  F_RDATA/F_ERR valid; 1 cycle after F_GNT
F_RDATA  out  XLEN  fetched instruction
F_ERR  out  1  fetch out of range or misaligned
P_WE  in  1  program write request, level, held until P_ACK
P_ADDR  in  32  program byte address
P_WDATA  in  XLEN  program data
P_ACK  out  1  single-cycle pulse, write completed or dropped
P_ERR  out  1  qualifies P_ACK: write dropped (range or alignment)
BUSY  out  1  clear sweep in progress

Behaviour:
- Reset, async on RST_N low: F_RVALID=0, F_RDATA=NOP_WORD, F_ERR=0, P_ACK=0, P_ERR=0.
  - Sweep counter = 0.
  - State = CLEAR if CLEAR_ON_RESET, else READY.
  - BUSY = 1 only in CLEAR.
  - F_GNT=0 while RST_N is low.
- Array contents are not reset. A reset mid-operation aborts the pending ACK/RVALID and restarts the sweep.
- States:
  - CLEAR: write NOP_WORD to word[cnt] each cycle; cnt += 1. At cnt == DEPTH-1, write it and go to READY. Takes exactly DEPTH cycles.
    - F_GNT=0. P_WE is not accepted and stays pending.
  - READY: normal operation. No exit except reset.
- Word index = addr[AW+1:2]. In range iff addr[31:AW+2]==0. Aligned iff addr[1:0]==0.
- Program write:
  - Accepted when READY && P_WE && !P_ACK.
  - A valid address writes the array at the accept edge.
  - P_ACK pulses the following cycle. P_ERR=1 with it if the write was dropped.
  - The write port ignores P_WE while P_ACK=1, so a held P_WE cannot double-write.
- Fetch:
  - F_GNT = READY && F_REQ && !(P_WE && !P_ACK). The programming port has strict priority; fetch stalls during a write cycle.
  - On grant, the cycle after: F_RVALID=1.
    - Valid address: F_RDATA = word, F_ERR=0.
    - Invalid address: F_RDATA=NOP_WORD, F_ERR=1.
  - Without a grant: F_RVALID=0 and F_RDATA holds its last value.
  - Back-to-back grants give one result per cycle.
- A write and a fetch never occur in the same cycle (priority). A fetch granted the cycle after a write to the same word returns the new data.

Optional Feature:
IMEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit (^WDATA), computed on program writes and clear-sweep writes.
  - On fetch, a parity mismatch forces F_RDATA=NOP_WORD and F_ERR=1.
  - Adds output PAR_ERR (1 bit), sticky, set on any mismatch, cleared only by reset.
- Undefined: no parity storage, no PAR_ERR port. F_ERR covers range/alignment only.

Decomposition:
- Package imem_pkg holds:
  - NOP constant (32'h00000013)
  - state enum {CLEAR, READY}
  - default XLEN/DEPTH
- Sub-module imem_array holds the storage (DEPTH x (XLEN+parity)) with one write port and one registered read port. imem_ctrl holds the FSM, sweep counter, arbitration, range checks and ACK logic.

Test Plan:
- Reset with DEPTH=16, CLEAR_ON_RESET=1, F_REQ=1 -> BUSY=1 and F_GNT=0 for exactly 16 cycles; then fetch addr 0x3C -> F_RDATA=0x00000013, F_ERR=0.
- P_WE addr 0x8, data 0xDEADBEEF, held until ACK -> one P_ACK pulse, P_ERR=0; next-cycle fetch 0x8 -> 0xDEADBEEF one cycle after grant.
- P_WE and F_REQ asserted together -> F_GNT=0 that cycle; F_GNT=1 the cycle P_ACK is high; fetched data is the new word.
- Fetch 0x400 (DEPTH=256) and 0x6 -> F_RVALID with F_ERR=1, F_RDATA=0x00000013; write to 0x400 -> P_ACK with P_ERR=1 and array unchanged.
- RST_N low mid-write (P_WE accepted) -> no P_ACK, all outputs at reset values, sweep restarts.
- With IMEM_PARITY_EN: force-flip one stored bit via the bench -> fetch returns NOP, F_ERR=1, PAR_ERR stays 1 until reset.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory controller: default sizes,
// the NOP encoding used for error returns and the clear sweep, and the
// controller state type.
`timescale 1ns/1ps
package imem_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 256;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH words of W bits, one synchronous write port and
// one registered read port. The contents are never reset; only the read
// register is, so its value is defined before the first read.
`timescale 1ns/1ps
module imem_array #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // storage write, no reset so the array can map onto RAM
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // registered read port, updated only on an enabled read
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction memory controller: post-reset NOP clear sweep, fetch port with
// one-cycle read latency, UART programming port with single-pulse ACK, and
// range/alignment checking on both ports. The programming port has strict
// priority over fetch.
// Optional macro IMEM_PARITY_EN: stores an even-parity bit per word, turns a
// parity mismatch on fetch into a NOP/F_ERR return and adds a sticky PAR_ERR.
`timescale 1ns/1ps
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned    XLEN           = XLEN_DEF,
  parameter int unsigned    DEPTH          = DEPTH_DEF,
  parameter logic [XLEN-1:0] NOP_WORD      = XLEN'(NOP),
  parameter bit             CLEAR_ON_RESET = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            F_REQ,
  input  logic [31:0]     F_ADDR,
  output logic            F_GNT,
  output logic            F_RVALID,
  output logic [XLEN-1:0] F_RDATA,
  output logic            F_ERR,
  input  logic            P_WE,
  input  logic [31:0]     P_ADDR,
  input  logic [XLEN-1:0] P_WDATA,
  output logic            P_ACK,
  output logic            P_ERR,
  output logic            BUSY
`ifdef IMEM_PARITY_EN
  ,
  output logic            PAR_ERR
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int unsigned PW = 1;
`else
  localparam int unsigned PW = 0;
`endif
  localparam int unsigned W = XLEN + PW;
  localparam state_t INIT_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic            ready;
  logic            p_pending;
  logic            wr_acc;
  logic            p_ok;
  logic            f_ok;
  logic            rng_err;
  logic            par_bad;
  logic            arr_we;
  logic [AW-1:0]   arr_waddr;
  logic [W-1:0]    arr_wdata;
  logic [W-1:0]    arr_rdata;
  logic [XLEN-1:0] rd_word;

  assign ready     = (state == READY);
  assign p_pending = P_WE && !P_ACK;
  assign wr_acc    = ready && p_pending;
  assign p_ok      = (P_ADDR[31:AW+2] == '0) && (P_ADDR[1:0] == 2'b00);
  assign f_ok      = (F_ADDR[31:AW+2] == '0) && (F_ADDR[1:0] == 2'b00);

  // fetch is blocked in reset, during the sweep and on any pending write
  assign F_GNT = RST_N && ready && F_REQ && !p_pending;
  assign BUSY  = (state == CLEAR);

  // array write source: sweep NOPs while clearing, otherwise accepted writes
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = cnt;
    arr_wdata = '0;
    if (state == CLEAR) begin
      arr_we    = 1'b1;
`ifdef IMEM_PARITY_EN
      arr_wdata = {^NOP_WORD, NOP_WORD};
`else
      arr_wdata = NOP_WORD;
`endif
    end else if (wr_acc && p_ok) begin
      arr_we    = 1'b1;
      arr_waddr = P_ADDR[AW+1:2];
`ifdef IMEM_PARITY_EN
      arr_wdata = {^P_WDATA, P_WDATA};
`else
      arr_wdata = P_WDATA;
`endif
    end
  end

  imem_array #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .CLK   (CLK),
    .RST_N (RST_N),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (F_GNT),
    .raddr (F_ADDR[AW+1:2]),
    .rdata (arr_rdata)
  );

  assign rd_word = arr_rdata[XLEN-1:0];

`ifdef IMEM_PARITY_EN
  assign par_bad = (^rd_word) != arr_rdata[XLEN];
`else
  assign par_bad = 1'b0;
`endif

  // Range errors are registered alongside the read so F_RDATA is a mux of
  // held registers and keeps its last value when nothing is granted.
  assign F_RDATA = (rng_err || par_bad) ? NOP_WORD : rd_word;
  assign F_ERR   = F_RVALID && (rng_err || par_bad);

  // controller state and sweep counter; CLEAR exits after DEPTH writes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= INIT_STATE;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(DEPTH - 1)) begin
        state <= READY;
      end
    end
  end

  // programming port acknowledge, one pulse per accepted write
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      P_ACK <= 1'b0;
      P_ERR <= 1'b0;
    end else begin
      P_ACK <= wr_acc;
      P_ERR <= wr_acc && !p_ok;
    end
  end

  // fetch response valid and range-error select, captured on grant
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      F_RVALID <= 1'b0;
      rng_err  <= 1'b1;
    end else begin
      F_RVALID <= F_GNT;
      if (F_GNT) begin
        rng_err <= !f_ok;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  // sticky parity error flag, set by any in-range fetch with bad parity
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PAR_ERR <= 1'b0;
    end else if (F_RVALID && !rng_err && par_bad) begin
      PAR_ERR <= 1'b1;
    end
  end
`endif

endmodule
